periph_async_rx: RTL and testbench

Receiver stage directly downstream of the CPU-side asynchronous sender: answers its four-phase send/ack handshake, one data bit per handshake. Bits are assembled MSB-first into a WIDTH-bit word, which is presented to the local consumer through a valid/ready port. The block backpressures the sender by withholding ack when it has no room for a completed word.

---
 rtl/periph_async_pkg.sv | 15 +
 rtl/sync_2ff.sv | 31 +++
 rtl/periph_async_rx.sv | 131 +++++++++++++
 tb/tb_periph_async_rx.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/periph_async_pkg.sv
// Shared definitions for the asynchronous-handshake receiver.
package periph_async_pkg;

   // Receiver FSM states; 2'b11 is unused and recovers to IDLE.
   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      CAPTURE = 2'b01,
      ACK     = 2'b10
   } rx_state_e;

   // Legal range of the assembled word width.
   localparam int WIDTH_MIN = 2;
   localparam int WIDTH_MAX = 32;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit; clears to 0 on reset.
module sync_2ff (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta_q, meta_d;
   logic sync_q, sync_d;

   // Next values simply shift the input down the two-stage chain.
   always_comb begin
      meta_d = d;
      sync_d = meta_q;
   end

   // Synchronizer register chain with asynchronous active-low clear.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/periph_async_rx.sv
// Four-phase send/ack receiver: one bit per handshake, assembled MSB-first
// into a WIDTH-bit word offered on a valid/ready port. The sender is held
// off only when a bit would complete a word that has nowhere to go.
module periph_async_rx
   import periph_async_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     send,
   input  logic                     data,
   output logic                     ack,
   output logic [WIDTH-1:0]         out_word,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [$clog2(WIDTH)-1:0] bit_cnt
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

   if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_width_check
      $error("periph_async_rx: WIDTH out of range");
   end

   logic send_s;
   logic data_s;

   rx_state_e        state_q, state_d;
   logic             ack_q, ack_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [WIDTH-1:0] out_word_q, out_word_d;
   logic             out_valid_q, out_valid_d;
   logic [CW-1:0]    bit_cnt_q, bit_cnt_d;

   logic word_done;
   logic blocked;

   sync_2ff u_sync_send (
      .clk (clk),
      .rst (rst),
      .d   (send),
      .q   (send_s)
   );

   sync_2ff u_sync_data (
      .clk (clk),
      .rst (rst),
      .d   (data),
      .q   (data_s)
   );

   // The next bit completes a word; if the previous word is still unconsumed
   // that bit must wait, partial-word bits never do.
   assign word_done = (bit_cnt_q == LAST_IDX);
   assign blocked   = out_valid_q && !out_ready && word_done;

   // Handshake FSM, bit assembly and output-word hand-off.
   always_comb begin
      state_d     = state_q;
      ack_d       = ack_q;
      shreg_d     = shreg_q;
      out_word_d  = out_word_q;
      out_valid_d = out_valid_q;
      bit_cnt_d   = bit_cnt_q;

      // Consumer takes the word; a word completing on this edge overrides below.
      if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end

      case (state_q)
         IDLE: begin
            ack_d = 1'b0;
            if (send_s && !blocked) begin
               state_d = CAPTURE;
            end
         end
         CAPTURE: begin
            shreg_d = {shreg_q[WIDTH-2:0], data_s};
            if (word_done) begin
               out_word_d  = {shreg_q[WIDTH-2:0], data_s};
               out_valid_d = 1'b1;
               bit_cnt_d   = '0;
            end else begin
               bit_cnt_d = bit_cnt_q + CW'(1);
            end
            state_d = ACK;
            ack_d   = 1'b1;
         end
         ACK: begin
            if (send_s) begin
               ack_d = 1'b1;
            end else begin
               state_d = IDLE;
               ack_d   = 1'b0;
            end
         end
         default: begin
            state_d = IDLE;
            ack_d   = 1'b0;
         end
      endcase
   end

   // State and datapath registers; reset discards any partial word.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         ack_q       <= 1'b0;
         shreg_q     <= '0;
         out_word_q  <= '0;
         out_valid_q <= 1'b0;
         bit_cnt_q   <= '0;
      end else begin
         state_q     <= state_d;
         ack_q       <= ack_d;
         shreg_q     <= shreg_d;
         out_word_q  <= out_word_d;
         out_valid_q <= out_valid_d;
         bit_cnt_q   <= bit_cnt_d;
      end
   end

   assign ack       = ack_q;
   assign out_word  = out_word_q;
   assign out_valid = out_valid_q;
   assign bit_cnt   = bit_cnt_q;

endmodule

// File: tb/tb_periph_async_rx.sv
// Bench for periph_async_rx: cycle reference model, per-cycle compare,
// directed handshake scenarios and a randomized word stream with random
// consumer backpressure.
module tb_periph_async_rx;

   localparam int W     = 8;
   localparam int CW    = $clog2(W);
   localparam int BOUND = 300;

   logic          clk;
   logic          rst;
   logic          send;
   logic          data;
   logic          ack;
   logic [W-1:0]  out_word;
   logic          out_valid;
   logic          out_ready;
   logic [CW-1:0] bit_cnt;

   int n_pass;
   int n_total;
   logic rand_rdy;

   periph_async_rx #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .send      (send),
      .data      (data),
      .ack       (ack),
      .out_word  (out_word),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .bit_cnt   (bit_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   // phase: 0 waiting for request, 1 taking the bit, 2 holding ack high.
   logic         m_s1, m_s2, m_d1, m_d2;
   int           m_phase;
   logic         m_ack;
   logic         m_valid;
   logic [W-1:0] m_word;
   int           m_cnt;
   logic [W-1:0] m_acc;

   always @(posedge clk or negedge rst) begin : model
      int           phase_n;
      int           cnt_n;
      logic         ack_n;
      logic         valid_n;
      logic [W-1:0] word_n;
      logic [W-1:0] acc_n;
      if (!rst) begin
         m_s1 <= 0; m_s2 <= 0; m_d1 <= 0; m_d2 <= 0;
         m_phase <= 0; m_ack <= 0; m_valid <= 0;
         m_word <= '0; m_cnt <= 0; m_acc <= '0;
      end else begin
         phase_n = m_phase;
         cnt_n   = m_cnt;
         ack_n   = m_ack;
         word_n  = m_word;
         acc_n   = m_acc;
         valid_n = m_valid && !out_ready;
         if (m_phase == 0) begin
            ack_n = 0;
            if (m_s2 && !(m_valid && !out_ready && m_cnt == W - 1)) phase_n = 1;
         end else if (m_phase == 1) begin
            acc_n = W'(m_acc * 2 + m_d2);
            if (m_cnt == W - 1) begin
               word_n  = acc_n;
               valid_n = 1;
               cnt_n   = 0;
            end else begin
               cnt_n = m_cnt + 1;
            end
            phase_n = 2;
            ack_n   = 1;
         end else begin
            if (!m_s2) begin
               phase_n = 0;
               ack_n   = 0;
            end
         end
         m_s1 <= send; m_s2 <= m_s1; m_d1 <= data; m_d2 <= m_d1;
         m_phase <= phase_n; m_ack <= ack_n; m_valid <= valid_n;
         m_word <= word_n; m_cnt <= cnt_n; m_acc <= acc_n;
      end
   end

   // ---------------- output monitors ----------------
   int           vcnt;
   logic [W-1:0] last_word;
   logic [W-1:0] acc_q[$];

   initial begin
      vcnt = 0;
      last_word = '0;
   end

   always @(negedge clk) begin
      if (out_valid) begin
         vcnt      <= vcnt + 1;
         last_word <= out_word;
      end
   end

   always @(posedge clk) begin
      if (rst && out_valid && out_ready) acc_q.push_back(out_word);
   end

   // ---------------- checking helpers ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      else n_pass++;
   endtask

   task automatic compare_loop();
      forever begin
         @(negedge clk);
         chk("ack", 32'(ack), 32'(m_ack));
         chk("out_valid", 32'(out_valid), 32'(m_valid));
         chk("out_word", 32'(out_word), 32'(m_word));
         chk("bit_cnt", 32'(bit_cnt), 32'(m_cnt));
      end
   endtask

   task automatic wait_ack(input logic lvl, input string nm);
      int n;
      n = 0;
      while (ack !== lvl && n < BOUND) begin
         @(negedge clk);
         if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
         n++;
      end
      chk(nm, 32'(ack), 32'(lvl));
   endtask

   task automatic send_bit(input logic b);
      @(negedge clk);
      data = b;
      send = 1'b1;
      wait_ack(1'b1, "ack_rise");
      send = 1'b0;
      wait_ack(1'b0, "ack_fall");
      repeat ($urandom_range(0, 3)) @(negedge clk);
   endtask

   task automatic send_word(input logic [W-1:0] w);
      for (int i = W - 1; i >= 0; i--) send_bit(w[i]);
   endtask

   task automatic count_ack_edges(input string nm);
      int edges;
      edges = 0;
      do begin
         @(posedge clk);
         #1;
         edges++;
      end while (!ack && edges < 20);
      chk(nm, 32'(edges), 32'd4);
   endtask

   // Global time limit so the run can never hang.
   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   initial begin
      int           v0;
      int           s0;
      logic [W-1:0] rw;
      logic [W-1:0] exp_q[$];
      n_pass = 0;
      n_total = 0;
      rand_rdy = 1'b0;
      rst = 1'b1;
      send = 1'b1;
      data = 1'b1;
      out_ready = 1'b1;
      #1 rst = 1'b0;

      fork
         compare_loop();
      join_none

      // Reset held 3 cycles with send high.
      repeat (3) @(negedge clk);
      chk("rst_ack", 32'(ack), 32'd0);
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_word", 32'(out_word), 32'd0);
      chk("rst_bit_cnt", 32'(bit_cnt), 32'd0);
      v0 = vcnt;
      #1 rst = 1'b1;
      count_ack_edges("ack_edges_after_reset");

      // First bit (1) already acked; finish 8'hA5 = 1,0,1,0,0,1,0,1.
      @(negedge clk);
      send = 1'b0;
      wait_ack(1'b0, "ack_fall");
      send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b0);
      send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
      repeat (3) @(negedge clk);
      chk("word1_value", 32'(last_word), 32'hA5);
      chk("word1_pulse_len", 32'(vcnt - v0), 32'd1);

      // Backpressure: A5 held, last bit of 3C stalled until out_ready.
      @(negedge clk);
      out_ready = 1'b0;
      send_word(8'hA5);
      send_bit(1'b0); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
      send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
      @(negedge clk);
      data = 1'b0;
      send = 1'b1;
      repeat (20) @(negedge clk);
      chk("bp_ack_withheld", 32'(ack), 32'd0);
      chk("bp_word_held", 32'(out_word), 32'hA5);
      chk("bp_valid_held", 32'(out_valid), 32'd1);
      out_ready = 1'b1;
      wait_ack(1'b1, "bp_ack_after_ready");
      chk("bp_word2", 32'(out_word), 32'h3C);
      chk("bp_word2_valid", 32'(out_valid), 32'd1);
      send = 1'b0;
      wait_ack(1'b0, "ack_fall");

      // Reset mid-word discards partial bits.
      for (int i = 0; i < 5; i++) send_bit(1'($urandom_range(0, 1)));
      @(negedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      chk("midrst_bit_cnt", 32'(bit_cnt), 32'd0);
      chk("midrst_valid", 32'(out_valid), 32'd0);
      v0 = vcnt;
      send_word(8'hFF);
      repeat (3) @(negedge clk);
      chk("midrst_word_ff", 32'(last_word), 32'hFF);
      chk("midrst_pulse_len", 32'(vcnt - v0), 32'd1);

      // Reset during ACK with send held high.
      @(negedge clk);
      data = 1'b1;
      send = 1'b1;
      wait_ack(1'b1, "ack_rise");
      @(negedge clk);
      #1 rst = 1'b0;
      #1 chk("ackrst_async_drop", 32'(ack), 32'd0);
      @(negedge clk);
      #1 rst = 1'b1;
      count_ack_edges("ack_edges_after_ackrst");
      @(negedge clk);
      send = 1'b0;
      wait_ack(1'b0, "ack_fall");
      rw = W'($urandom);
      for (int i = W - 2; i >= 0; i--) send_bit(rw[i]);
      repeat (3) @(negedge clk);
      chk("ackrst_word", 32'(last_word), 32'({1'b1, rw[W-2:0]}));

      // Randomized word stream with random consumer backpressure.
      s0 = acc_q.size();
      rand_rdy = 1'b1;
      for (int k = 0; k < 6; k++) begin
         rw = W'($urandom);
         exp_q.push_back(rw);
         send_word(rw);
      end
      rand_rdy = 1'b0;
      out_ready = 1'b1;
      repeat (5) @(negedge clk);
      chk("rand_word_count", 32'(acc_q.size() - s0), 32'(exp_q.size()));
      for (int k = 0; k < exp_q.size(); k++) begin
         if (s0 + k < acc_q.size()) chk("rand_word", 32'(acc_q[s0 + k]), 32'(exp_q[k]));
         else chk("rand_word_missing", 32'd0, 32'(exp_q[k]));
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
